debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Conditions a raw, asynchronous, bouncy input (push-button or switch) into a clean, glitch-free level.
- Output `db` feeds the `sig` input of `edge_detector` directly; the edge detector then turns each debounced rising edge into a one-cycle `tick`.
- Structure: a synchronizer chain, then a 4-state stability FSM with a qualification counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `in`; legal range is 2 or more.
- STABLE_CYCLES, 8, consecutive cycles the synchronized input must hold a new value before `db` follows; legal range is 1 or more.
- GLITCH_W, 8, width of the glitch counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; low clears all state immediately.
- in  input  1  raw asynchronous input; may bounce and glitch.
- db  output  1  debounced level; registered; connects to `edge_detector.sig`.
- glitch_cnt  output  GLITCH_W  count of rejected transitions; present only when GLITCH_CNT_EN is defined.

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops = 0, state = ZERO, counter = 0, db = 0, glitch_cnt = 0. Release is synchronous in effect: the first update happens on the first clk rising edge after rst goes high.
- Synchronizer: `in` passes through SYNC_STAGES flops; the last stage is `s`. The FSM reads only `s`, never `in`.
- Counter width: $clog2(STABLE_CYCLES), minimum 1 bit. It never wraps, because it resets on every entry into a WAIT state.
- FSM transitions, evaluated on each rising clk edge:
  - ZERO (db=0): if s=1, go to WAIT1 and set cnt=0; otherwise stay.
  - WAIT1 (db=0):
    - if s=0, go to ZERO (glitch rejected);
    - else if cnt==STABLE_CYCLES-1, go to ONE;
    - else cnt++.
  - ONE (db=1): if s=0, go to WAIT0 and set cnt=0; otherwise stay.
  - WAIT0 (db=1):
    - if s=1, go to ONE (glitch rejected);
    - else if cnt==STABLE_CYCLES-1, go to ZERO;
    - else cnt++.
- db is driven from a flop (1 in ONE/WAIT0, 0 in ZERO/WAIT1). It is never combinational from `in`.
- Latency: after `in` changes and then holds steady, db changes on the (SYNC_STAGES+STABLE_CYCLES+1)th rising edge after the change. With defaults, that is the 11th edge.
- Minimum accepted pulse: `s` must hold for STABLE_CYCLES+1 consecutive samples. Anything shorter produces no db change.
- Bounce: each reversal in a WAIT state returns to the previous stable state. The next reversal restarts qualification from cnt=0, so there is no partial credit.
- db never toggles twice within STABLE_CYCLES+1 cycles. Every db 0→1 transition corresponds to exactly one qualified press, so the downstream edge detector emits exactly one tick per press.
- Reset mid-operation (any state, including WAIT1 with cnt>0): immediate return to reset values. If the input is still high after reset release, it must requalify from ZERO.

Optional Feature:
- Macro: GLITCH_CNT_EN.
- When defined:
  - `glitch_cnt` port exists.
  - It increments by 1 on each WAIT1→ZERO or WAIT0→ONE transition.
  - It saturates at 2^GLITCH_W-1 and does not wrap.
  - It is cleared only by reset.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with in=1 for 3 cycles → db=0 and glitch_cnt=0 throughout. Release rst with in=1 held → db=1 on the 11th rising edge after release (SYNC_STAGES+STABLE_CYCLES+1 = 11).
- Clean press: in 0→1 between edges and held for 20 cycles → db stays 0 for 10 edges, rises on the 11th, and stays 1. Downstream edge_detector ticks exactly once.
- Glitch reject: in=1 for 5 cycles, then 0 → db stays 0 for the whole test; glitch_cnt=1 (with GLITCH_CNT_EN).
- Bounce train: in highs of 17, 8, 11 and 7 ns with lows of 3–13 ns at a 10 ns clock, then steady 1 for 300 ns → exactly one db 0→1 transition, after the steady period qualifies; glitch_cnt ≥ 1.
- Release: from db=1, in→0 with two 3-cycle bounces back to 1, then steady 0 → db falls exactly 11 edges after the last reversal to 0; glitch_cnt increments by 2.
- Reset mid-qualify: in=1, then drive rst low when the FSM has been in WAIT1 for 4 cycles → db=0 immediately. With in still 1 after release, db rises 11 edges after release, not earlier.

Source files
------------

// File: rtl/debouncer_if.sv
// Bus between a raw bouncy input source and the debouncer.
// GLITCH_CNT_EN adds the rejected-transition counter to the bus.
interface debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic in;
  logic db;
`ifdef GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output in, input db, input glitch_cnt);
  modport slave  (input in, output db, output glitch_cnt);
`else
  modport master (output in, input db);
  modport slave  (input in, output db);
`endif
endinterface

// File: rtl/debouncer.sv
// Debouncer: synchronizer chain feeding a 4-state stability FSM with a qualification counter.
// Optional feature macro: GLITCH_CNT_EN (saturating count of rejected transitions).
module debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int GLITCH_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  debouncer_if.slave  bus
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_db;
  logic                   w_db_nxt;
  logic                   w_s;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign bus.db = r_db;

  // Synchronizer chain; only its last stage is seen by the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in};
    end
  end

  // State, qualification counter and registered debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_ZERO;
      r_cnt   <= {CNT_W{1'b0}};
      r_db    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
    end
  end

  // Next-state: any reversal inside a WAIT state drops back with no partial credit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ZERO: begin
        if (w_s) begin
          w_state_nxt = ST_WAIT1;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_ZERO;
        end
      end
      ST_WAIT1: begin
        if (!w_s) begin
          w_state_nxt = ST_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ONE: begin
        if (!w_s) begin
          w_state_nxt = ST_WAIT0;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_WAIT0: begin
        if (w_s) begin
          w_state_nxt = ST_ONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_ZERO;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so db lands in a flop on the same edge
  always_comb begin
    w_db_nxt = 1'b0;
    case (w_state_nxt)
      ST_ONE, ST_WAIT0: w_db_nxt = 1'b1;
      ST_ZERO, ST_WAIT1: w_db_nxt = 1'b0;
      default: w_db_nxt = 1'b0;
    endcase
  end

`ifdef GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic                w_glitch;

  assign w_glitch       = ((r_state == ST_WAIT1) && !w_s) || ((r_state == ST_WAIT0) && w_s);
  assign bus.glitch_cnt = r_glitch_cnt;

  // Saturating count of rejected transitions, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_glitch_cnt <= {GLITCH_W{1'b0}};
    end else if (w_glitch && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + {{(GLITCH_W-1){1'b0}}, 1'b1};
    end else begin
      r_glitch_cnt <= r_glitch_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: directed scenarios plus random bounce, checked every cycle
// against a run-length reference model (db flips after STABLE_CYCLES+1 disagreeing samples).
module tb_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int GW     = 8;
  localparam int LAT    = SYNC + STABLE + 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   dut_rises;
  logic prev_db;

  int   q[$];
  logic m_db;
  int   m_run;
  int   m_gcnt;

  debouncer_if #(.GLITCH_W(GW)) bus ();

  debouncer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .GLITCH_W     (GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    q = {};
    for (int i = 0; i < SYNC; i++) q.push_back(0);
    m_db   = 1'b0;
    m_run  = 0;
    m_gcnt = 0;
  endtask

  // Reference: the FSM sees `in` delayed by SYNC edges; db follows after STABLE+1 agreeing samples
  initial begin
    int s;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        s = q.pop_front();
        q.push_back(int'(bus.in));
        if (s != int'(m_db)) begin
          m_run++;
          if (m_run == STABLE + 1) begin
            m_db  = ~m_db;
            m_run = 0;
          end
        end else begin
          if (m_run > 0 && m_gcnt < (2**GW) - 1) m_gcnt++;
          m_run = 0;
        end
      end
    end
  end

  initial begin
    prev_db   = 1'b0;
    dut_rises = 0;
    forever begin
      @(negedge clk);
      chk("db_vs_model", 32'(bus.db), 32'(m_db));
`ifdef GLITCH_CNT_EN
      chk("glitch_vs_model", 32'(bus.glitch_cnt), 32'(m_gcnt));
`endif
      if (bus.db === 1'b1 && prev_db === 1'b0) dut_rises++;
      prev_db = bus.db;
    end
  end

  task automatic measure(input logic target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.db === target) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int gcnt_now();
`ifdef GLITCH_CNT_EN
    return int'(bus.glitch_cnt);
`else
    return 0;
`endif
  endfunction

  initial begin
    int n;
    int r0;
    int g0;
    int d;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    bus.in   = 1'b1;

    // Reset held with input high, then release
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_db", 32'(bus.db), 32'd0);
`ifdef GLITCH_CNT_EN
      chk("rst_gcnt", 32'(bus.glitch_cnt), 32'd0);
`endif
    end
    @(negedge clk);
    #2 rst = 1'b1;
    measure(1'b1, 30, n);
    chk("rst_release_lat", 32'(n), 32'(LAT));

    // Clean press
    bus.in = 1'b0;
    repeat (20) @(negedge clk);
    r0 = dut_rises;
    bus.in = 1'b1;
    measure(1'b1, 30, n);
    chk("press_lat", 32'(n), 32'(LAT));
    repeat (10) @(negedge clk);
    chk("press_hold", 32'(bus.db), 32'd1);
    chk("press_ticks", 32'(dut_rises - r0), 32'd1);

    // Short glitch rejected
    bus.in = 1'b0;
    repeat (20) @(negedge clk);
    r0 = dut_rises;
    g0 = gcnt_now();
    bus.in = 1'b1;
    repeat (5) @(negedge clk);
    bus.in = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_db", 32'(bus.db), 32'd0);
    chk("glitch_rises", 32'(dut_rises - r0), 32'd0);
`ifdef GLITCH_CNT_EN
    chk("glitch_cnt_inc", 32'(gcnt_now() - g0), 32'd1);
`endif

    // Bounce train, then steady high
    r0 = dut_rises;
    g0 = gcnt_now();
    bus.in = 1'b1; #17;
    bus.in = 1'b0; #3;
    bus.in = 1'b1; #8;
    bus.in = 1'b0; #13;
    bus.in = 1'b1; #11;
    bus.in = 1'b0; #5;
    bus.in = 1'b1; #7;
    bus.in = 1'b0; #9;
    bus.in = 1'b1; #300;
    @(negedge clk);
    chk("bounce_db", 32'(bus.db), 32'd1);
    chk("bounce_rises", 32'(dut_rises - r0), 32'd1);
`ifdef GLITCH_CNT_EN
    chk("bounce_gcnt_ge1", 32'(gcnt_now() - g0 >= 1), 32'd1);
`endif

    // Release with two 3-cycle bounces back to high
    g0 = gcnt_now();
    bus.in = 1'b0;
    repeat (3) @(negedge clk);
    bus.in = 1'b1;
    repeat (3) @(negedge clk);
    bus.in = 1'b0;
    repeat (3) @(negedge clk);
    bus.in = 1'b1;
    repeat (3) @(negedge clk);
    bus.in = 1'b0;
    measure(1'b0, 30, n);
    chk("release_lat", 32'(n), 32'(LAT));
`ifdef GLITCH_CNT_EN
    chk("release_gcnt", 32'(gcnt_now() - g0), 32'd2);
`endif

    // Reset while WAIT1 has been qualifying for 4 cycles
    repeat (20) @(negedge clk);
    bus.in = 1'b1;
    repeat (SYNC + 1 + 4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_db", 32'(bus.db), 32'd0);
`ifdef GLITCH_CNT_EN
    chk("midrst_gcnt", 32'(bus.glitch_cnt), 32'd0);
`endif
    @(negedge clk);
    #2 rst = 1'b1;
    measure(1'b1, 30, n);
    chk("midrst_lat", 32'(n), 32'(LAT));

    // Random bounce with occasional long holds and resets
    for (int it = 0; it < 400; it++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(80, 200)) : int'($urandom_range(1, 40));
      if ((($time + 64'(d)) % 10) == 5) d++;
      #d;
      bus.in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
